// File: rtl/req_gnt_chk_pkg.sv
// Shared types for the req/gnt latency checker: channel FSM states, fail codes
// and the per-channel event payload.
package req_gnt_chk_pkg;

    localparam int unsigned CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chk_state_e;

    typedef enum logic [CODE_W-1:0] {
        EARLY    = 2'd0,
        TIMEOUT  = 2'd1,
        DROP     = 2'd2,
        SPURIOUS = 2'd3
    } fail_code_e;

    // One channel's verdict for one cycle
    typedef struct packed {
        logic       pass;
        logic       fail;
        fail_code_e code;
    } chk_evt_t;

endpackage

// File: rtl/req_gnt_chan.sv
// One req/gnt channel: IDLE/WAIT FSM with a latency counter and a registered
// pass/fail/code pulse. The unregistered verdict also feeds the shared counters.
module req_gnt_chan
    import req_gnt_chk_pkg::*;
#(
    parameter int unsigned MIN_LAT  = 2,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned REQ_HOLD = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     enable_i,
    input  logic     req_i,
    input  logic     gnt_i,
    output logic     pass_c_o,
    output logic     fail_c_o,
    output chk_evt_t evt_o
);

    localparam int unsigned      LAT_W = $clog2(MAX_LAT + 2);
    localparam logic [LAT_W-1:0] MIN_L = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_LAT);
    localparam bit               HOLD  = (REQ_HOLD != 0);

    chk_state_e       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    chk_evt_t         evt_q, evt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            evt_q   <= evt_d;
        end
    end

    // Next state; lat tracks cycles since acceptance while in WAIT
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        if (!enable_i) begin
            state_d = IDLE;
            lat_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    lat_d = '0;
                    if (req_i && !gnt_i) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (gnt_i || (lat_q == MAX_L) || (HOLD && !req_i)) begin
                        state_d = IDLE;
                        lat_d   = '0;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    lat_d   = '0;
                end
            endcase
        end
    end

    // Verdict for this cycle; grant beats timeout beats drop
    always_comb begin
        evt_d = '0;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (req_i && gnt_i) begin
                        if (MIN_LAT == 0) begin
                            evt_d.pass = 1'b1;
                        end else begin
                            evt_d.fail = 1'b1;
                            evt_d.code = EARLY;
                        end
                    end else if (!req_i && gnt_i) begin
                        evt_d.fail = 1'b1;
                        evt_d.code = SPURIOUS;
                    end
                end
                WAIT: begin
                    if (gnt_i) begin
                        if (lat_q < MIN_L) begin
                            evt_d.fail = 1'b1;
                            evt_d.code = EARLY;
                        end else begin
                            evt_d.pass = 1'b1;
                        end
                    end else if (lat_q == MAX_L) begin
                        evt_d.fail = 1'b1;
                        evt_d.code = TIMEOUT;
                    end else if (HOLD && !req_i) begin
                        evt_d.fail = 1'b1;
                        evt_d.code = DROP;
                    end
                end
                default: evt_d = '0;
            endcase
        end
    end

    assign pass_c_o = evt_d.pass;
    assign fail_c_o = evt_d.fail;
    assign evt_o    = evt_q;

endmodule

// File: rtl/req_gnt_latency_checker.sv
// Multi-channel req/gnt latency checker: per-channel window checks, sticky error
// flags and saturating global pass/error counters.
module req_gnt_latency_checker
    import req_gnt_chk_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned MIN_LAT  = 2,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned REQ_HOLD = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        pass,
    output logic [NUM_CH-1:0]        fail,
    output logic [CODE_W*NUM_CH-1:0] fail_code,
    output logic [NUM_CH-1:0]        err_sticky,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         err_count
);

    localparam int unsigned      PC_W    = $clog2(NUM_CH + 1);
    localparam int unsigned      SUM_W   = CNT_W + PC_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    if (NUM_CH < 1) begin : g_err_num_ch
        $error("req_gnt_latency_checker: NUM_CH must be >= 1");
    end
    if (MAX_LAT < 1) begin : g_err_max_lat
        $error("req_gnt_latency_checker: MAX_LAT must be >= 1");
    end
    if (MIN_LAT > MAX_LAT) begin : g_err_min_lat
        $error("req_gnt_latency_checker: MIN_LAT must not exceed MAX_LAT");
    end
    if (REQ_HOLD > 1) begin : g_err_req_hold
        $error("req_gnt_latency_checker: REQ_HOLD must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_err_cnt_w
        $error("req_gnt_latency_checker: CNT_W must be >= 1");
    end

    logic [NUM_CH-1:0] pass_vec_c, fail_vec_c;
    chk_evt_t          evt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        req_gnt_chan #(
            .MIN_LAT  (MIN_LAT),
            .MAX_LAT  (MAX_LAT),
            .REQ_HOLD (REQ_HOLD)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable_i (enable),
            .req_i    (req[i]),
            .gnt_i    (gnt[i]),
            .pass_c_o (pass_vec_c[i]),
            .fail_c_o (fail_vec_c[i]),
            .evt_o    (evt[i])
        );
        assign pass[i]                        = evt[i].pass;
        assign fail[i]                        = evt[i].fail;
        assign fail_code[CODE_W*i +: CODE_W]  = evt[i].code;
    end

    logic [PC_W-1:0]   pass_pc_c, err_pc_c;
    logic [SUM_W-1:0]  pass_sum_c, err_sum_c;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;

    // Counters see the same-cycle verdicts so they line up with the pulses
    always_comb begin
        pass_pc_c  = PC_W'($countones(pass_vec_c));
        err_pc_c   = PC_W'($countones(fail_vec_c));
        pass_sum_c = SUM_W'(pass_cnt_q) + SUM_W'(pass_pc_c);
        err_sum_c  = SUM_W'(err_cnt_q) + SUM_W'(err_pc_c);
        pass_cnt_d = (pass_sum_c > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum_c[CNT_W-1:0];
        err_cnt_d  = (err_sum_c > CNT_MAX) ? {CNT_W{1'b1}} : err_sum_c[CNT_W-1:0];
        sticky_d   = sticky_q | fail_vec_c;
        if (clear) begin
            pass_cnt_d = '0;
            err_cnt_d  = '0;
            sticky_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            sticky_q   <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign pass_count = pass_cnt_q;
    assign err_count  = err_cnt_q;
    assign err_sticky = sticky_q;

endmodule
